spi_accel_ctrl: RTL and testbench
=================================

# spi_accel_ctrl

Transaction sequencer that sits directly upstream of the SPI shift engine, `Send_and_Receive`. After reset it configures the 3-axis accelerometer with a fixed write sequence. It then polls the X/Y data registers at a fixed rate using one multi-byte read per poll. Each completed read is latched and presented to the display/processing logic with a one-cycle valid strobe.

## Interface
Parameters:
- `SI_DW`, 16: width of the command word (address byte in bits [15:8], data byte in bits [7:0]).
- `SO_DW`, 16: width of each axis sample.
- `CMD_INIT0`, 16'h3108: first init write (DATA_FORMAT = full-resolution).
- `CMD_INIT1`, 16'h2D08: second init write (POWER_CTL = measure).
- `CMD_READ`, 16'hF200: multi-byte read. Bit 15 = read, bit 14 = MB, address 0x32.
- `POLL_DIV`, 5000: `ispi_clk` cycles from the end of one read to the next read's GO.
- `TIMEOUT`, 1023: maximum `ispi_clk` cycles to wait for `iSPI_END` after GO.

Ports:
- `ispi_clk`, in, 1: clock. The same clock drives the SPI engine's control logic.
- `ireset`, in, 1: asynchronous, active-low reset.
- `ienable`, in, 1: run/stop request.
- `oDATA_P2S`, out, SI_DW: command word to the engine.
- `oSPI_GO`, out, 1: one-cycle start pulse to the engine.
- `iSPI_END`, in, 1: one-cycle transfer-complete pulse from the engine.
- `iDATA_S2P_X`, in, SO_DW: X sample from the engine.
- `iDATA_S2P_Y`, in, SO_DW: Y sample from the engine.
- `oX`, out, SO_DW: latched X sample.
- `oY`, out, SO_DW: latched Y sample.
- `oVALID`, out, 1: one-cycle pulse, high when `oX`/`oY` have just updated.
- `oINIT_DONE`, out, 1: high once both init writes have completed.
- `oBUSY`, out, 1: high while a transaction is outstanding (GO issued, END not yet seen).
- `oERR`, out, 1: sticky timeout flag.

## Operation
- States: IDLE, INIT_GO, INIT_WAIT, POLL_WAIT, READ_GO, READ_WAIT, LATCH.
- Register `init_idx` (1 bit) selects the current init command: 0 → `CMD_INIT0`, 1 → `CMD_INIT1`.
- IDLE:
  - `ienable`=1 and `oINIT_DONE`=0 → INIT_GO with `init_idx`=0.
  - `ienable`=1 and `oINIT_DONE`=1 → READ_GO.
- INIT_GO: drive `oDATA_P2S` = selected init command, pulse `oSPI_GO`, go to INIT_WAIT.
- INIT_WAIT, on `iSPI_END`:
  - If `init_idx`=0: set `init_idx`=1, return to INIT_GO.
  - Otherwise: set `oINIT_DONE`=1, clear the poll counter, go to POLL_WAIT.
- POLL_WAIT:
  - The poll counter increments each cycle; at `POLL_DIV`-1 go to READ_GO.
  - `ienable`=0 → IDLE immediately.
- READ_GO: drive `oDATA_P2S` = `CMD_READ`, pulse `oSPI_GO`, go to READ_WAIT.
- READ_WAIT: on `iSPI_END`, capture `iDATA_S2P_X`/`iDATA_S2P_Y` into `oX`/`oY`, go to LATCH.
- LATCH:
  - Pulse `oVALID` and clear the poll counter.
  - `ienable`=1 → POLL_WAIT; `ienable`=0 → IDLE.
- `oDATA_P2S` is held stable from the GO cycle through the END cycle, because the engine reads it continuously during the transfer. Between transactions it keeps its last value.
- `ienable`=0 in either WAIT state does not abort the transfer. The current transaction completes, then the block goes to IDLE. An init sequence that is cut short this way restarts from `init_idx`=0 on re-enable.
- Timeout:
  - A wait counter clears on GO and increments in INIT_WAIT/READ_WAIT.
  - Reaching `TIMEOUT` without END sets `oERR`=1, clears `oINIT_DONE` and `init_idx`, and goes to INIT_GO (re-initialise the sensor).
  - `oERR` is cleared only by reset.
- `iSPI_END` outside the WAIT states is ignored.
- Any undefined state → IDLE.

## Timing
- Reset values:
  - `oDATA_P2S`=0, `oSPI_GO`=0, `oX`=`oY`=0, `oVALID`=0, `oINIT_DONE`=0, `oBUSY`=0, `oERR`=0.
  - State = IDLE, all counters = 0.
- All outputs are registered.
- `oSPI_GO` is high for exactly one cycle. `oBUSY` rises in the same cycle as GO and falls in the cycle after END is sampled.
- END sampled in READ_WAIT at edge n:
  - `oX`/`oY` update at edge n.
  - `oVALID` is high for the cycle following edge n+1.
- From END sampled to the next GO:
  - Poll loop: `POLL_DIV`+2 cycles.
  - Between the two init writes: 1 cycle. The engine returns to its own IDLE on the same edge it raises END, so a GO one cycle later is accepted.
- END and the timeout terminal count in the same cycle: END wins, no error.
- Asserting `ireset` mid-transfer forces the reset values immediately. The engine must be reset by the same `ireset`.

## Test plan
- Reset, then `ienable`=1: GO with `oDATA_P2S`=16'h3108, then after END a GO with 16'h2D08, then `oINIT_DONE`=1. Exactly 2 GO pulses.
- Engine model returns X=16'h0123, Y=16'hFEDC: `oX`/`oY` take these values with one `oVALID` pulse. With `POLL_DIV`=8, the next GO comes 10 cycles after END.
- Engine model never returns END after a READ_GO: after 1023 cycles `oERR`=1 and `oINIT_DONE`=0, and the next GO carries 16'h3108.
- `ienable` dropped mid-READ_WAIT: no new GO. `oVALID` still pulses once, then the block sits in IDLE. On re-enable the next GO is `CMD_READ` immediately, with no init.
- `ireset` pulsed during INIT_WAIT: all outputs return to their reset values. On release with `ienable`=1 the init sequence restarts at 16'h3108.

Source files
------------

// File: rtl/spi_accel_ctrl.sv
// Accelerometer transaction sequencer ahead of the SPI shift engine.
// Runs the init writes once, then polls X/Y with one multi-byte read per period.
module spi_accel_ctrl #(
  parameter int SI_DW = 16,
  parameter int SO_DW = 16,
  parameter logic [SI_DW-1:0] CMD_INIT0 = 16'h3108,
  parameter logic [SI_DW-1:0] CMD_INIT1 = 16'h2D08,
  parameter logic [SI_DW-1:0] CMD_READ  = 16'hF200,
  parameter int POLL_DIV = 5000,
  parameter int TIMEOUT  = 1023
) (
  input  logic             ispi_clk,
  input  logic             ireset,
  input  logic             ienable,
  output logic [SI_DW-1:0] oDATA_P2S,
  output logic             oSPI_GO,
  input  logic             iSPI_END,
  input  logic [SO_DW-1:0] iDATA_S2P_X,
  input  logic [SO_DW-1:0] iDATA_S2P_Y,
  output logic [SO_DW-1:0] oX,
  output logic [SO_DW-1:0] oY,
  output logic             oVALID,
  output logic             oINIT_DONE,
  output logic             oBUSY,
  output logic             oERR
);

  localparam int PW = $clog2(POLL_DIV + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    INIT_GO,
    INIT_WAIT,
    POLL_WAIT,
    READ_GO,
    READ_WAIT,
    LATCH
  } state_t;

  state_t          state;
  logic            init_idx;
  logic [PW-1:0]   poll_cnt;
  logic [TW-1:0]   wait_cnt;

  logic            tmo_hit;
  assign tmo_hit = (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge ispi_clk or negedge ireset) begin
    if (!ireset) begin
      state      <= IDLE;
      init_idx   <= 1'b0;
      poll_cnt   <= '0;
      wait_cnt   <= '0;
      oDATA_P2S  <= '0;
      oSPI_GO    <= 1'b0;
      oX         <= '0;
      oY         <= '0;
      oVALID     <= 1'b0;
      oINIT_DONE <= 1'b0;
      oBUSY      <= 1'b0;
      oERR       <= 1'b0;
    end else begin
      oSPI_GO <= 1'b0;
      oVALID  <= 1'b0;
      case (state)
        IDLE: begin
          if (ienable) begin
            if (oINIT_DONE) begin
              state <= READ_GO;
            end else begin
              init_idx <= 1'b0;
              state    <= INIT_GO;
            end
          end
        end
        INIT_GO: begin
          oDATA_P2S <= init_idx ? CMD_INIT1 : CMD_INIT0;
          oSPI_GO   <= 1'b1;
          oBUSY     <= 1'b1;
          wait_cnt  <= '0;
          state     <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (iSPI_END) begin
            oBUSY <= 1'b0;
            if (!init_idx) begin
              // a stop between the writes leaves init_idx at 0 so init restarts
              if (ienable) begin
                init_idx <= 1'b1;
                state    <= INIT_GO;
              end else begin
                state <= IDLE;
              end
            end else begin
              oINIT_DONE <= 1'b1;
              poll_cnt   <= '0;
              state      <= ienable ? POLL_WAIT : IDLE;
            end
          end else if (tmo_hit) begin
            oERR       <= 1'b1;
            oINIT_DONE <= 1'b0;
            oBUSY      <= 1'b0;
            init_idx   <= 1'b0;
            state      <= INIT_GO;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        POLL_WAIT: begin
          if (!ienable) begin
            state <= IDLE;
          end else if (poll_cnt == PW'(POLL_DIV - 1)) begin
            state <= READ_GO;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
          end
        end
        READ_GO: begin
          oDATA_P2S <= CMD_READ;
          oSPI_GO   <= 1'b1;
          oBUSY     <= 1'b1;
          wait_cnt  <= '0;
          state     <= READ_WAIT;
        end
        READ_WAIT: begin
          if (iSPI_END) begin
            oX    <= iDATA_S2P_X;
            oY    <= iDATA_S2P_Y;
            oBUSY <= 1'b0;
            state <= LATCH;
          end else if (tmo_hit) begin
            oERR       <= 1'b1;
            oINIT_DONE <= 1'b0;
            oBUSY      <= 1'b0;
            init_idx   <= 1'b0;
            state      <= INIT_GO;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        LATCH: begin
          oVALID   <= 1'b1;
          poll_cnt <= '0;
          state    <= ienable ? POLL_WAIT : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_accel_ctrl.sv
// Directed/randomized bench for spi_accel_ctrl with a simple SPI engine responder.
// Expected gaps and values come from the sequencing rules, not the RTL.
module tb_spi_accel_ctrl;

  localparam int PD = 8;
  localparam int TO = 1023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        end_p = 1'b0;
  logic [15:0] dx = '0;
  logic [15:0] dy = '0;
  logic [15:0] data;
  logic        go;
  logic [15:0] ox;
  logic [15:0] oy;
  logic        vld;
  logic        done;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;
  int gos = 0;

  spi_accel_ctrl #(
    .POLL_DIV(PD),
    .TIMEOUT (TO)
  ) dut (
    .ispi_clk   (clk),
    .ireset     (rst_n),
    .ienable    (en),
    .oDATA_P2S  (data),
    .oSPI_GO    (go),
    .iSPI_END   (end_p),
    .iDATA_S2P_X(dx),
    .iDATA_S2P_Y(dy),
    .oX         (ox),
    .oY         (oy),
    .oVALID     (vld),
    .oINIT_DONE (done),
    .oBUSY      (busy),
    .oERR       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (go) gos <= gos + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_data"}, 32'(data), 32'h0);
    chk({tag, "_go"}, 32'(go), 32'h0);
    chk({tag, "_x"}, 32'(ox), 32'h0);
    chk({tag, "_y"}, 32'(oy), 32'h0);
    chk({tag, "_vld"}, 32'(vld), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  task automatic wait_go(input int lim, output bit found, output int cyc,
                         output int nv, output int vpos, output int epos);
    found = 1'b0;
    cyc = 0;
    nv = 0;
    vpos = -1;
    epos = -1;
    while (!found && cyc < lim) begin
      @(negedge clk);
      cyc++;
      if (vld) begin
        nv++;
        if (vpos < 0) vpos = cyc;
      end
      if (err && epos < 0) epos = cyc;
      if (go) found = 1'b1;
    end
  endtask

  task automatic expect_go(input string tag, input int lim, input int gap,
                           input logic [15:0] cmd, output int nv,
                           output int vpos, output int epos);
    bit found;
    int cyc;
    wait_go(lim, found, cyc, nv, vpos, epos);
    chk({tag, "_found"}, 32'(found), 32'h1);
    if (found) begin
      chk({tag, "_gap"}, 32'(cyc), 32'(gap));
      chk({tag, "_cmd"}, 32'(data), 32'(cmd));
      chk({tag, "_busy"}, 32'(busy), 32'h1);
    end
  endtask

  // Engine responder: END after lat cycles; samples are only valid with END.
  task automatic respond(input string tag, input int lat,
                         input logic [15:0] cmd, input logic [15:0] x,
                         input logic [15:0] y, input bit rd);
    for (int i = 0; i < lat; i++) begin
      dx = 16'($urandom);
      dy = 16'($urandom);
      @(negedge clk);
      chk({tag, "_wbusy"}, 32'(busy), 32'h1);
      chk({tag, "_wgo"}, 32'(go), 32'h0);
      chk({tag, "_hold"}, 32'(data), 32'(cmd));
    end
    end_p = 1'b1;
    dx = x;
    dy = y;
    @(negedge clk);
    end_p = 1'b0;
    dx = 16'($urandom);
    dy = 16'($urandom);
    chk({tag, "_ebusy"}, 32'(busy), 32'h0);
    if (rd) begin
      chk({tag, "_x"}, 32'(ox), 32'(x));
      chk({tag, "_y"}, 32'(oy), 32'(y));
    end
  endtask

  initial begin
    int nv, vpos, epos, cyc, g0;
    bit found;
    logic [15:0] x, y;

    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst_n = 1'b1;
    end_p = 1'b1;
    @(negedge clk);
    end_p = 1'b0;
    wait_go(6, found, cyc, nv, vpos, epos);
    chk("idle_nogo", 32'(found), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    g0 = gos;
    en = 1'b1;
    expect_go("init0", 10, 2, 16'h3108, nv, vpos, epos);
    respond("init0", int'($urandom_range(2, 12)), 16'h3108, 0, 0, 0);
    chk("init0_notdone", 32'(done), 32'h0);
    expect_go("init1", 10, 1, 16'h2D08, nv, vpos, epos);
    respond("init1", int'($urandom_range(2, 12)), 16'h2D08, 0, 0, 0);
    chk("init_done", 32'(done), 32'h1);
    chk("init_gos", 32'(gos - g0), 32'h2);
    expect_go("read0", PD + 10, PD + 1, 16'hF200, nv, vpos, epos);

    for (int k = 0; k < 4; k++) begin
      x = (k == 0) ? 16'h0123 : 16'($urandom);
      y = (k == 0) ? 16'hFEDC : 16'($urandom);
      respond("read", int'($urandom_range(2, 20)), 16'hF200, x, y, 1);
      expect_go("poll", PD + 10, PD + 2, 16'hF200, nv, vpos, epos);
      chk("poll_nvalid", 32'(nv), 32'h1);
      chk("poll_vpos", 32'(vpos), 32'h1);
    end

    x = 16'($urandom);
    y = 16'($urandom);
    respond("edge", TO - 1, 16'hF200, x, y, 1);
    chk("edge_err", 32'(err), 32'h0);
    expect_go("edge_poll", PD + 10, PD + 2, 16'hF200, nv, vpos, epos);
    chk("edge_nvalid", 32'(nv), 32'h1);

    en = 1'b0;
    x = 16'($urandom);
    y = 16'($urandom);
    respond("stop", int'($urandom_range(2, 20)), 16'hF200, x, y, 1);
    wait_go(30, found, cyc, nv, vpos, epos);
    chk("stop_nogo", 32'(found), 32'h0);
    chk("stop_nvalid", 32'(nv), 32'h1);
    chk("stop_vpos", 32'(vpos), 32'h1);
    chk("stop_done", 32'(done), 32'h1);
    en = 1'b1;
    expect_go("reen", 10, 2, 16'hF200, nv, vpos, epos);

    expect_go("tmo", TO + 50, TO + 1, 16'h3108, nv, vpos, epos);
    chk("tmo_epos", 32'(epos), 32'(TO));
    chk("tmo_err", 32'(err), 32'h1);
    chk("tmo_done", 32'(done), 32'h0);
    respond("tinit0", int'($urandom_range(2, 12)), 16'h3108, 0, 0, 0);
    expect_go("tinit1", 10, 1, 16'h2D08, nv, vpos, epos);

    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_chk("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    expect_go("rinit0", 10, 2, 16'h3108, nv, vpos, epos);
    chk("rinit_err", 32'(err), 32'h0);

    en = 1'b0;
    respond("cut", int'($urandom_range(2, 12)), 16'h3108, 0, 0, 0);
    wait_go(20, found, cyc, nv, vpos, epos);
    chk("cut_nogo", 32'(found), 32'h0);
    chk("cut_done", 32'(done), 32'h0);
    en = 1'b1;
    expect_go("cinit0", 10, 2, 16'h3108, nv, vpos, epos);
    respond("cinit0", int'($urandom_range(2, 12)), 16'h3108, 0, 0, 0);
    expect_go("cinit1", 10, 1, 16'h2D08, nv, vpos, epos);
    respond("cinit1", int'($urandom_range(2, 12)), 16'h2D08, 0, 0, 0);
    chk("cinit_done", 32'(done), 32'h1);
    expect_go("cread", PD + 10, PD + 1, 16'hF200, nv, vpos, epos);
    x = 16'($urandom);
    y = 16'($urandom);
    respond("cread", int'($urandom_range(2, 20)), 16'hF200, x, y, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
